router_dst_fifo: RTL and testbench
==================================

Name: router_dst_fifo

Overview:
- Per-destination output buffer of the router. It is the source end of the destination port protocol.
- Stores packet bytes written by the router core and presents vld_out / data_out to the destination reader, which pulls bytes with read_enb.
- Tracks packet boundaries from the header byte.
- Flushes itself (soft reset) when the destination stops reading.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, ≥4.
- TIMEOUT, 30, consecutive unread cycles with vld_out=1 before soft reset.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- write_enb  in  1  write strobe from router core
- lfd_state  in  1  marks data_in as packet header byte
- data_in  in  8  byte to store
- read_enb  in  1  read request from destination
- data_out  out  8  registered read data
- vld_out  out  1  FIFO non-empty (combinational from state regs = ~empty)
- full  out  1  DEPTH entries held
- empty  out  1  zero entries held
- soft_reset  out  1  one-cycle pulse on timeout flush
- pkt_last  out  1  qualifies data_out as final (parity) byte of a packet

Behaviour:
- Storage: DEPTH x 9 bits, {lfd_state, data_in}. Write/read pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
- full = (addr bits equal && wrap bits differ); empty = (pointers equal).
- Reset (async): pointers 0, data_out 8'h00, pkt_last 0, soft_reset 0, timeout counter 0, remaining counter 0. Memory is not cleared.
- Write accepted iff write_enb && !full.
  - A write while full is dropped; there is no pass-through even if a read fires the same cycle.
- Read accepted iff read_enb && !empty.
  - data_out and pkt_last update at the clock edge that accepts the read, so they are valid the cycle after read_enb is sampled (latency 1).
  - data_out holds its last value otherwise.
- Simultaneous read and write, not full and not empty: both accepted, occupancy unchanged.
- Write to empty FIFO with read_enb high: write accepted, read ignored; vld_out rises next cycle.
- Packet tracking (remaining counter, 7 bits):
  - Reading a header entry (bit8=1) loads remaining = hdr[7:2] + 1 (payload + parity); pkt_last=0.
  - Each later accepted read decrements remaining. pkt_last=1 on the read where remaining==1, else 0.
  - A header read while remaining≠0 (truncated packet) reloads the counter; no error is raised.
- Timeout:
  - The counter increments each cycle vld_out && !read_enb.
  - It clears to 0 when read_enb=1 or empty.
  - When the counter equals TIMEOUT-1 and increments, soft_reset pulses for 1 cycle.
  - In that same edge: pointers, remaining and timeout counter clear; data_out←0; pkt_last←0.
  - Any write or read in the flush cycle is dropped.
  - empty=1 the following cycle.
- Reset asserted mid-packet: immediate flush, same values as above; soft_reset stays 0.

Optional Feature:
- Macro ROUTER_DST_FIFO_OVF_EN.
- Defined: extra output ovf_err (1 bit). It is sticky, set on the edge after write_enb && full, and cleared only by reset or soft_reset. Reset value 0.
- Undefined: port and logic absent. Overflowing writes are silently dropped.

Decomposition:
- Shared package router_pkg:
  - typedef fifo_entry_t (struct: logic hdr; logic [7:0] data).
  - constants HDR_LEN_MSB=7, HDR_LEN_LSB=2, DEFAULT_TIMEOUT=30.
- One natural sub-module: router_dst_timeout (timeout counter plus soft_reset pulse generator). The remainder is flat.

Test Plan:
- Write header 8'h0C (len 3, lfd_state=1), 3 payload bytes, parity → read continuously. Expected: 5 bytes out in order, each 1 cycle after read_enb; pkt_last=1 only with parity; empty=1 after.
- Fill 16 writes with no reads → full=1. Then a 17th write → dropped; reading 16 returns the first 16 values; ovf_err=1 when macro defined.
- Write 1 byte, then hold read_enb=0 → soft_reset pulses exactly on the 30th unread cycle; empty=1 and data_out=0 next cycle. Repeat with read_enb on cycle 29 → no soft_reset.
- Concurrent write/read each cycle at occupancy 8 for 20 cycles → occupancy stays 8, data order preserved, pointers wrap correctly.
- Assert reset asynchronously mid-packet (between clock edges) → all outputs at reset values immediately; first post-reset header tracked correctly.
- read_enb high while empty, simultaneous write → no read accepted, data_out unchanged, vld_out=1 next cycle.

Source files
------------

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared types, header-field positions and helpers for the
//               router destination-side blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    // Header length field position inside the header byte
    localparam int HDR_LEN_MSB     = 7;
    localparam int HDR_LEN_LSB     = 2;
    localparam int DEFAULT_TIMEOUT = 30;

    // One FIFO slot: header marker plus the stored byte
    typedef struct packed {
        logic       hdr;
        logic [7:0] data;
    } fifo_entry_t;

    // Bytes still to come after a header: payload length plus parity byte
    function automatic logic [6:0] hdr_remaining(
        input logic [HDR_LEN_MSB-HDR_LEN_LSB:0] len
    );
        return 7'(len) + 7'd1;
    endfunction

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_dst_timeout.sv
`default_nettype none
// ============================================================================
// Module      : router_dst_timeout
// Description : Counts consecutive cycles in which the FIFO holds data but
//               the destination does not read. On the cycle the count would
//               pass TIMEOUT-1, o_expire requests a flush and o_soft_reset
//               pulses for one cycle afterwards.
// Revision    : 1.0 - initial release
// ============================================================================
module router_dst_timeout #(
    parameter int TIMEOUT = 30
) (
    input  logic clock,
    input  logic reset,
    input  logic i_vld,
    input  logic i_read_enb,
    output logic o_expire,
    output logic o_soft_reset
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    logic [TW-1:0] r_count;
    logic          r_soft_reset;

    // Flush request: data waiting, no read, and the limit reached this cycle
    assign o_expire     = i_vld && !i_read_enb && (r_count == TW'(TIMEOUT - 1));
    assign o_soft_reset = r_soft_reset;

    // Unread-cycle counter and the one-cycle soft reset pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count      <= '0;
            r_soft_reset <= 1'b0;
        end else begin
            r_soft_reset <= o_expire;
            if (o_expire || i_read_enb || !i_vld) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + TW'(1);
            end
        end
    end

endmodule : router_dst_timeout
`default_nettype wire

// File: rtl/router_dst_fifo.sv
`default_nettype none
// ============================================================================
// Module      : router_dst_fifo
// Description : Per-destination output buffer. Stores {header flag, byte}
//               entries from the router core, presents them to the
//               destination reader with one cycle read latency, tracks packet
//               boundaries to flag the parity byte, and flushes itself when
//               the reader stalls for TIMEOUT cycles.
//               Optional overflow flag: define ROUTER_DST_FIFO_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module router_dst_fifo
    import router_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       write_enb,
    input  logic       lfd_state,
    input  logic [7:0] data_in,
    input  logic       read_enb,
    output logic [7:0] data_out,
    output logic       vld_out,
    output logic       full,
    output logic       empty,
    output logic       soft_reset,
    output logic       pkt_last
`ifdef ROUTER_DST_FIFO_OVF_EN
    ,
    output logic       ovf_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    fifo_entry_t r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [6:0]    r_remaining;
    logic [7:0]    r_data_out;
    logic          r_pkt_last;

    logic          w_full;
    logic          w_empty;
    logic          w_expire;
    logic          w_wr_acc;
    logic          w_rd_acc;
    fifo_entry_t   w_wr_entry;
    fifo_entry_t   w_rd_entry;

    // Same slot index with opposite wrap bits means a full lap ahead
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // The flush cycle swallows any transfer
    assign w_wr_acc = write_enb && !w_full  && !w_expire;
    assign w_rd_acc = read_enb  && !w_empty && !w_expire;

    assign w_wr_entry.hdr  = lfd_state;
    assign w_wr_entry.data = data_in;
    assign w_rd_entry      = r_mem[r_rd_ptr[AW-1:0]];

    assign full     = w_full;
    assign empty    = w_empty;
    assign vld_out  = !w_empty;
    assign data_out = r_data_out;
    assign pkt_last = r_pkt_last;

    router_dst_timeout #(
        .TIMEOUT      (TIMEOUT)
    ) u_timeout (
        .clock        (clock),
        .reset        (reset),
        .i_vld        (!w_empty),
        .i_read_enb   (read_enb),
        .o_expire     (w_expire),
        .o_soft_reset (soft_reset)
    );

    // Storage array; contents are left as-is by reset and flush
    always_ff @(posedge clock) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_wr_entry;
        end
    end

    // Read/write pointers, cleared by reset or timeout flush
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_expire) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Registered read data and packet-boundary tracking
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data_out  <= 8'h00;
            r_pkt_last  <= 1'b0;
            r_remaining <= 7'd0;
        end else if (w_expire) begin
            r_data_out  <= 8'h00;
            r_pkt_last  <= 1'b0;
            r_remaining <= 7'd0;
        end else if (w_rd_acc) begin
            r_data_out <= w_rd_entry.data;
            if (w_rd_entry.hdr) begin
                // A header always restarts tracking, even mid-packet
                r_remaining <= hdr_remaining(w_rd_entry.data[HDR_LEN_MSB:HDR_LEN_LSB]);
                r_pkt_last  <= 1'b0;
            end else begin
                r_pkt_last <= (r_remaining == 7'd1);
                if (r_remaining != 7'd0) begin
                    r_remaining <= r_remaining - 7'd1;
                end
            end
        end
    end

`ifdef ROUTER_DST_FIFO_OVF_EN
    logic r_ovf_err;

    assign ovf_err = r_ovf_err;

    // Sticky overflow flag, cleared only by reset or a timeout flush
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ovf_err <= 1'b0;
        end else if (w_expire) begin
            r_ovf_err <= 1'b0;
        end else if (write_enb && w_full) begin
            r_ovf_err <= 1'b1;
        end
    end
`endif

endmodule : router_dst_fifo
`default_nettype wire

// File: tb/tb_router_dst_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_dst_fifo
// Description : Randomized plus directed bench for router_dst_fifo with a
//               queue-based reference model and a read-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_dst_fifo;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 30;

    logic       clock = 1'b0;
    logic       reset;
    logic       write_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       vld_out;
    logic       full;
    logic       empty;
    logic       soft_reset;
    logic       pkt_last;
`ifdef ROUTER_DST_FIFO_OVF_EN
    logic       ovf_err;
`endif

    router_dst_fifo #(
        .DEPTH      (DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .vld_out    (vld_out),
        .full       (full),
        .empty      (empty),
        .soft_reset (soft_reset),
        .pkt_last   (pkt_last)
`ifdef ROUTER_DST_FIFO_OVF_EN
        ,
        .ovf_err    (ovf_err)
`endif
    );

    always #5 clock = ~clock;

    // Reference model state
    typedef struct { bit hdr; bit [7:0] data; } ent_t;
    typedef struct { bit [7:0] d; bit last; } exp_t;
    ent_t     mq[$];
    exp_t     sb[$];
    int       m_rem;
    int       m_tcnt;
    bit [7:0] m_dout;
    bit       m_plast;
    bit       m_sr;
    bit       m_ovf;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        m_rem = 0; m_tcnt = 0; m_dout = 8'h00; m_plast = 1'b0; m_sr = 1'b0; m_ovf = 1'b0;
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge
    task automatic model_edge(input bit we, input bit lfd, input bit [7:0] din, input bit re);
        int   pre;
        ent_t e;
        exp_t x;
        ent_t n;
        pre = mq.size();
        if (pre > 0 && !re && m_tcnt == TIMEOUT - 1) begin
            mq.delete();
            m_rem = 0; m_dout = 8'h00; m_plast = 1'b0; m_tcnt = 0; m_sr = 1'b1; m_ovf = 1'b0;
        end else begin
            m_sr = 1'b0;
            if (we && pre == DEPTH) m_ovf = 1'b1;
            if (re && pre > 0) begin
                e = mq.pop_front();
                if (e.hdr) begin
                    m_rem   = int'(e.data[7:2]) + 1;
                    m_plast = 1'b0;
                end else begin
                    m_plast = (m_rem == 1);
                    if (m_rem > 0) m_rem--;
                end
                m_dout = e.data;
                x.d = m_dout; x.last = m_plast;
                sb.push_back(x);
            end
            if (we && pre < DEPTH) begin
                n.hdr = lfd; n.data = din;
                mq.push_back(n);
            end
            m_tcnt = (pre == 0 || re) ? 0 : m_tcnt + 1;
        end
    endtask

    task automatic check_state();
        chk("empty", int'(empty), int'(mq.size() == 0));
        chk("full", int'(full), int'(mq.size() == DEPTH));
        chk("vld_out", int'(vld_out), int'(mq.size() != 0));
        chk("soft_reset", int'(soft_reset), int'(m_sr));
        chk("data_out", int'(data_out), int'(m_dout));
        chk("pkt_last", int'(pkt_last), int'(m_plast));
`ifdef ROUTER_DST_FIFO_OVF_EN
        chk("ovf_err", int'(ovf_err), int'(m_ovf));
`endif
    endtask

    task automatic step(input bit we, input bit lfd, input bit [7:0] din, input bit re);
        @(negedge clock);
        check_state();
        write_enb = we; lfd_state = lfd; data_in = din; read_enb = re;
        @(posedge clock);
        model_edge(we, lfd, din, re);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    // Scoreboard monitor: a read handshake at a rising edge yields data next half cycle
    bit fire = 1'b0;
    always @(posedge clock) fire <= read_enb && vld_out && !reset;

    always @(negedge clock) begin
        exp_t x;
        if (fire) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected_read: got data_out=%0h expected no read", data_out);
            end else begin
                x = sb.pop_front();
                chk("sb_data", int'(data_out), int'(x.d));
                chk("sb_last", int'(pkt_last), int'(x.last));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; write_enb = 1'b0; lfd_state = 1'b0; data_in = 8'h00; read_enb = 1'b0;
        model_reset();
        #12;
        chk("rst_empty", int'(empty), 1);
        chk("rst_vld", int'(vld_out), 0);
        chk("rst_dout", int'(data_out), 0);
        chk("rst_sr", int'(soft_reset), 0);
        @(negedge clock);
        reset = 1'b0;

        // Packet: header 0x0C (3 payload bytes) + parity, then continuous read
        step(1'b1, 1'b1, 8'h0C, 1'b0);
        step(1'b1, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b0, 8'h22, 1'b0);
        step(1'b1, 1'b0, 8'h33, 1'b0);
        step(1'b1, 1'b0, 8'h9E, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        idle(1);
        #1;
        chk("pkt_empty_after", int'(empty), 1);
        chk("pkt_parity_last", int'(pkt_last), 1);

        // Fill to full, overflow attempt, then read everything back
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i * 7 + 3), 1'b0);
        step(1'b1, 1'b0, 8'hEE, 1'b0);
        #1;
        chk("full_after_17", int'(full), 1);
        drain();

        // Timeout: exactly 30 unread cycles trigger the flush
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        idle(29);
        #1;
        chk("to_pre_sr", int'(soft_reset), 0);
        chk("to_pre_vld", int'(vld_out), 1);
        idle(1);
        #1;
        chk("to_sr", int'(soft_reset), 1);
        chk("to_empty", int'(empty), 1);
        chk("to_dout", int'(data_out), 0);
        idle(1);
        #1;
        chk("to_sr_pulse", int'(soft_reset), 0);

        // Read on the 29th cycle avoids the flush
        step(1'b1, 1'b0, 8'h5C, 1'b0);
        idle(28);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            #1;
            chk("no_to_sr", int'(soft_reset), 0);
        end

        // Concurrent write/read at occupancy 8 across pointer wrap
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'($urandom), 1'b1);
        drain();

        // Read while empty with a simultaneous write
        step(1'b1, 1'b0, 8'h5A, 1'b1);
        #1;
        chk("emptyrw_vld", int'(vld_out), 1);
        chk("emptyrw_dout", int'(data_out), int'(m_dout));
        drain();

        // Asynchronous reset in the middle of a packet
        step(1'b1, 1'b1, 8'h08, 1'b0);
        step(1'b1, 1'b0, 8'h41, 1'b0);
        step(1'b1, 1'b0, 8'h42, 1'b1);
        @(negedge clock);
        check_state();
        #2;
        reset = 1'b1; write_enb = 1'b0; read_enb = 1'b0;
        #1;
        chk("arst_empty", int'(empty), 1);
        chk("arst_vld", int'(vld_out), 0);
        chk("arst_dout", int'(data_out), 0);
        chk("arst_last", int'(pkt_last), 0);
        chk("arst_sr", int'(soft_reset), 0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        step(1'b1, 1'b1, 8'h04, 1'b0);
        step(1'b1, 1'b0, 8'h77, 1'b0);
        step(1'b1, 1'b0, 8'h66, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        #1;
        chk("arst_hdr_last", int'(pkt_last), 1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, 7) == 0,
                 8'($urandom), $urandom_range(0, 99) < 50);
        end
        drain();
        idle(2);

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_router_dst_fifo
`default_nettype wire
